// File: rtl/motion_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : motion_detect_pkg
// Brief    : Shared types and constants for the motion_detect pixel pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package motion_detect_pkg;

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_EMIT  = 1'b1
    } state_t;

    localparam int WIDTH_DEFAULT  = 768;
    localparam int HEIGHT_DEFAULT = 576;
    localparam int PIXELS         = WIDTH_DEFAULT * HEIGHT_DEFAULT;
    localparam int PIX_CNT_W      = $clog2(PIXELS);

    localparam logic [23:0] COLOR_RED   = 24'h0000FF;
    localparam logic [23:0] COLOR_BLACK = 24'h000000;

    // Never returns zero so a degenerate one-pixel frame still gets a counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/motion_highlight.sv
`default_nettype none
// ============================================================================
// Module   : motion_highlight
// Brief    : Pairs mask bytes with original BGR pixels, paints motion pixels
//            with HIGHLIGHT_COLOR and pulses frame_done on each frame's end.
//            Optional MOTION_HIGHLIGHT_COUNT_EN adds a per-frame motion count.
// Revision : 1.0 - initial release
// ============================================================================
module motion_highlight
    import motion_detect_pkg::*;
#(
    parameter int          WIDTH           = WIDTH_DEFAULT,
    parameter int          HEIGHT          = HEIGHT_DEFAULT,
    parameter logic [23:0] HIGHLIGHT_COLOR = COLOR_RED
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mask_empty,
    output logic        mask_rd_en,
    input  logic [7:0]  mask_dout,
    input  logic        img_empty,
    output logic        img_rd_en,
    input  logic [23:0] img_dout,
    input  logic        out_full,
    output logic        out_wr_en,
    output logic [23:0] out_din,
    output logic        frame_done
`ifdef MOTION_HIGHLIGHT_COUNT_EN
    ,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] motion_count
`endif
);

    localparam int               NPIX     = WIDTH * HEIGHT;
    localparam int               CNT_W    = cnt_width(NPIX);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);

    state_t             state_q, state_d;
    logic [23:0]        pix_q, pix_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic               frame_done_q, frame_done_d;

    logic               fetch_ok;
    logic               fetch;
    logic               write;
    logic               last_pix;
    logic               is_motion;
    logic [23:0]        pix_c;

    assign fetch_ok  = !mask_empty && !img_empty;
    assign is_motion = (mask_dout != 8'h00);
    assign pix_c     = is_motion ? HIGHLIGHT_COLOR : img_dout;
    assign last_pix  = (pix_cnt_q == LAST_PIX);

    always_comb begin
        state_d = state_q;
        fetch   = 1'b0;
        write   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (fetch_ok) begin
                    fetch   = 1'b1;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                // A draining write may refill in the same cycle for 1 pixel/cycle.
                if (!out_full) begin
                    write = 1'b1;
                    if (fetch_ok) begin
                        fetch = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pix_d        = fetch ? pix_c : pix_q;
        pix_cnt_d    = pix_cnt_q;
        frame_done_d = 1'b0;
        if (write) begin
            pix_cnt_d    = last_pix ? '0 : pix_cnt_q + CNT_W'(1);
            frame_done_d = last_pix;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            pix_q        <= COLOR_BLACK;
            pix_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Strobes are gated by reset so nothing leaks while it is held low.
    assign mask_rd_en = reset && fetch;
    assign img_rd_en  = reset && fetch;
    assign out_wr_en  = reset && write;
    assign out_din    = pix_q;
    assign frame_done = frame_done_q;

`ifdef MOTION_HIGHLIGHT_COUNT_EN
    localparam int MC_W = $clog2(NPIX + 1);

    logic            motion_q, motion_d;
    logic [MC_W-1:0] acc_q, acc_d;
    logic [MC_W-1:0] motion_count_q, motion_count_d;

    always_comb begin
        motion_d       = fetch ? is_motion : motion_q;
        acc_d          = acc_q;
        motion_count_d = motion_count_q;
        if (write) begin
            // The last pixel's flag is folded into the latched total.
            if (last_pix) begin
                motion_count_d = acc_q + MC_W'(motion_q);
                acc_d          = '0;
            end else begin
                acc_d = acc_q + MC_W'(motion_q);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            motion_q       <= 1'b0;
            acc_q          <= '0;
            motion_count_q <= '0;
        end else begin
            motion_q       <= motion_d;
            acc_q          <= acc_d;
            motion_count_q <= motion_count_d;
        end
    end

    assign motion_count = motion_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_motion_highlight.sv
`default_nettype none
// ============================================================================
// Module   : tb_motion_highlight
// Brief    : Scoreboard bench for motion_highlight with FIFO models and a
//            queue-based reference of the highlight and frame rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motion_highlight;

    localparam int          W   = 4;
    localparam int          H   = 2;
    localparam int          PIX = W * H;
    localparam logic [23:0] RED = 24'h0000FF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mask_empty = 1'b1;
    logic        img_empty  = 1'b1;
    logic        out_full   = 1'b0;
    logic [7:0]  mask_dout  = 8'h00;
    logic [23:0] img_dout   = 24'h0;
    wire         mask_rd_en;
    wire         img_rd_en;
    wire         out_wr_en;
    wire  [23:0] out_din;
    wire         frame_done;
`ifdef MOTION_HIGHLIGHT_COUNT_EN
    wire  [$clog2(PIX+1)-1:0] motion_count;
`endif

    motion_highlight #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .mask_empty (mask_empty),
        .mask_rd_en (mask_rd_en),
        .mask_dout  (mask_dout),
        .img_empty  (img_empty),
        .img_rd_en  (img_rd_en),
        .img_dout   (img_dout),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .out_din    (out_din),
        .frame_done (frame_done)
`ifdef MOTION_HIGHLIGHT_COUNT_EN
        ,
        .motion_count (motion_count)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mq[$];
    logic [23:0] iq[$];
    logic [24:0] exp_q[$];
    logic [23:0] out_log[$];

    bit m_en = 1'b1;
    bit i_en = 1'b1;
    bit pop_seen = 1'b0;
    int n_writes = 0;
    int n_pops = 0;
    int n_fd = 0;
    int wcount = 0;
    bit fd_pend = 1'b0;
    int macc = 0;
    int mc_pend = 0;
    bit mc_pend_v = 1'b0;

    logic [7:0]  dmask [PIX] = '{8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h80, 8'h00};
    logic [23:0] dexp  [PIX] = '{24'h102030, 24'h0000FF, 24'h102032, 24'h0000FF,
                                 24'h102034, 24'h102035, 24'h0000FF, 24'h102037};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive();
        mask_empty = !(m_en && mq.size() > 0);
        img_empty  = !(i_en && iq.size() > 0);
        mask_dout  = (mq.size() > 0) ? mq[0] : 8'h00;
        img_dout   = (iq.size() > 0) ? iq[0] : 24'h0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (pop_seen) begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (iq.size() > 0) void'(iq.pop_front());
            pop_seen = 1'b0;
        end
        drive();
    endtask

    task automatic clear_model();
        exp_q.delete();
        wcount    = 0;
        fd_pend   = 1'b0;
        macc      = 0;
        mc_pend_v = 1'b0;
        pop_seen  = 1'b0;
    endtask

    // Scoreboard monitor: pushes on observed pops, pops and compares on writes.
    always @(negedge clock) begin
        logic [24:0] e;
        if (reset) begin
            check("rd_en_pair", {31'b0, mask_rd_en}, {31'b0, img_rd_en});
            if (mask_rd_en || img_rd_en)
                check("pop_when_empty", {30'b0, mask_empty, img_empty}, 32'd0);
            if (out_full) begin
                check("write_while_full", {31'b0, out_wr_en}, 32'd0);
                if (exp_q.size() > 0)
                    check("hold_din", {8'b0, out_din}, {8'b0, exp_q[0][23:0]});
            end
            check("frame_done", {31'b0, frame_done}, {31'b0, fd_pend});
`ifdef MOTION_HIGHLIGHT_COUNT_EN
            if (mc_pend_v)
                check("motion_count", 32'(motion_count), 32'(mc_pend));
`endif
            if (frame_done) n_fd++;
            fd_pend   = 1'b0;
            mc_pend_v = 1'b0;
            if (out_wr_en) begin
                n_writes++;
                out_log.push_back(out_din);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got %0h, expected no write at %0t", out_din, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_din", {8'b0, out_din}, {8'b0, e[23:0]});
                    macc += int'(e[24]);
                    wcount++;
                    if (wcount == PIX) begin
                        wcount    = 0;
                        fd_pend   = 1'b1;
                        mc_pend   = macc;
                        mc_pend_v = 1'b1;
                        macc      = 0;
                    end
                end
            end
            if (mask_rd_en && !mask_empty && !img_empty) begin
                exp_q.push_back({(mask_dout != 8'h00), (mask_dout != 8'h00) ? RED : img_dout});
                pop_seen = 1'b1;
                n_pops++;
            end
        end
    end

    task automatic run_directed();
        int cyc;
        int start;
        int fd0;
        out_log.delete();
        fd0 = n_fd;
        for (int i = 0; i < PIX; i++) begin
            mq.push_back(dmask[i]);
            iq.push_back(24'h102030 + 24'(i));
        end
        m_en = 1'b1; i_en = 1'b1; out_full = 1'b0;
        drive();
        start = n_writes;
        cyc = 0;
        while (n_writes < start + PIX && cyc < 40) begin
            step();
            cyc++;
        end
        check("frame_cycles", 32'(cyc), 32'd9);
        step();
        check("frame_done_count", 32'(n_fd - fd0), 32'd1);
        check("log_size", 32'(out_log.size()), 32'(PIX));
        for (int i = 0; i < PIX && i < out_log.size(); i++)
            check("directed_pixel", {8'b0, out_log[i]}, {8'b0, dexp[i]});
`ifdef MOTION_HIGHLIGHT_COUNT_EN
        check("directed_motion_count", 32'(motion_count), 32'd3);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int w0;
        int fd0;
        int k;

        drive();
        #2;
        check("rst_mask_rd_en", {31'b0, mask_rd_en}, 32'd0);
        check("rst_img_rd_en", {31'b0, img_rd_en}, 32'd0);
        check("rst_out_wr_en", {31'b0, out_wr_en}, 32'd0);
        check("rst_out_din", {8'b0, out_din}, 32'd0);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
`ifdef MOTION_HIGHLIGHT_COUNT_EN
        check("rst_motion_count", 32'(motion_count), 32'd0);
`endif
        @(posedge clock);
        #3 reset = 1'b1;

        run_directed();
        run_directed();

        // Mask available, image withheld: nothing may be popped or written.
        mq.push_back(8'h00);
        iq.push_back(24'hABCDEF);
        m_en = 1'b1; i_en = 1'b0;
        drive();
        p0 = n_pops; w0 = n_writes;
        repeat (5) step();
        check("lone_fifo_pops", 32'(n_pops - p0), 32'd0);
        check("lone_fifo_writes", 32'(n_writes - w0), 32'd0);
        i_en = 1'b1;
        drive();
        repeat (3) step();
        check("pair_pops", 32'(n_pops - p0), 32'd1);
        check("pair_writes", 32'(n_writes - w0), 32'd1);

        // Output back-pressure in S_EMIT.
        for (int i = 0; i < 4; i++) begin
            mq.push_back(8'($urandom_range(0, 1) ? 0 : $urandom));
            iq.push_back(24'($urandom));
        end
        p0 = n_pops; w0 = n_writes;
        drive();
        step();
        out_full = 1'b1;
        repeat (3) step();
        check("full_pops", 32'(n_pops - p0), 32'd1);
        check("full_writes", 32'(n_writes - w0), 32'd0);
        out_full = 1'b0;
        k = 0;
        while ((mq.size() > 0 || exp_q.size() > 0) && k < 20) begin
            step();
            k++;
        end
        check("full_total_writes", 32'(n_writes - w0), 32'd4);
        check("full_total_pops", 32'(n_pops - p0), 32'd4);

        // Reset mid-frame after three writes.
        for (int i = 0; i < PIX; i++) begin
            mq.push_back(8'($urandom));
            iq.push_back(24'($urandom));
        end
        drive();
        w0 = n_writes;
        k = 0;
        while (n_writes - w0 < 3 && k < 20) begin
            step();
            k++;
        end
        reset = 1'b0;
        #1;
        check("mid_rst_mask_rd_en", {31'b0, mask_rd_en}, 32'd0);
        check("mid_rst_img_rd_en", {31'b0, img_rd_en}, 32'd0);
        check("mid_rst_out_wr_en", {31'b0, out_wr_en}, 32'd0);
        check("mid_rst_out_din", {8'b0, out_din}, 32'd0);
        check("mid_rst_frame_done", {31'b0, frame_done}, 32'd0);
        clear_model();
        mq.delete();
        iq.delete();
        drive();
        @(posedge clock);
        #3 reset = 1'b1;
        for (int i = 0; i < PIX; i++) begin
            mq.push_back(8'($urandom));
            iq.push_back(24'($urandom));
        end
        drive();
        fd0 = n_fd; w0 = n_writes;
        k = 0;
        while (n_writes - w0 < PIX && k < 40) begin
            step();
            k++;
            if (n_writes - w0 < PIX)
                check("no_early_frame_done", 32'(n_fd - fd0), 32'd0);
        end
        step();
        check("post_rst_frame_done", 32'(n_fd - fd0), 32'd1);

        // Randomised traffic across many frames.
        for (int c = 0; c < 2000; c++) begin
            step();
            if (mq.size() < 6 && $urandom_range(0, 1) == 1) begin
                mq.push_back($urandom_range(0, 1) ? 8'h00 : 8'($urandom));
                iq.push_back(24'($urandom));
            end
            m_en     = ($urandom_range(0, 3) != 0);
            i_en     = ($urandom_range(0, 3) != 0);
            out_full = ($urandom_range(0, 3) == 0);
            drive();
        end
        m_en = 1'b1; i_en = 1'b1; out_full = 1'b0;
        drive();
        k = 0;
        while ((mq.size() > 0 || exp_q.size() > 0) && k < 100) begin
            step();
            k++;
        end
        repeat (2) step();
        check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("drain_inputs_empty", 32'(mq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
